// File: rtl/alu_controller_mdu.sv
// alu_controller_mdu
//   EX-stage ALU control for an RV32I core extended with RV32M.  Decodes
//   ALUOp/Funct3/Funct7 into the 4-bit ALU operation code and runs an iterative
//   multiply/divide unit (MDU) that stalls the pipeline while it computes.
//
//   Ports
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     ALUOp[1:0]     00 load/store/auipc/jalr, 01 branch, 10 R/I-type, 11 jal/lui
//     Funct7, Funct3 instruction fields instr[31:25], instr[14:12]
//     IsImm          I-type ALU instruction (Funct7 only meaningful for SRAI)
//     MdValid        EX holds a valid, non-flushed instruction
//     Flush          synchronous abort of any MDU operation
//     OpA, OpB       rs1/rs2 operands, sampled when the MDU accepts
//     Operation      combinational ALU op code
//     MdSel          writeback takes MdResult instead of the ALU result
//     Stall          hold PC/IF/ID/EX while the MDU is busy
//     MdDone         one-cycle pulse, MdResult valid
//     MdResult       MDU result, held until the next completion
module alu_controller_mdu #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            IsImm,
   input  logic            MdValid,
   input  logic            Flush,
   input  logic [XLEN-1:0] OpA,
   input  logic [XLEN-1:0] OpB,
   output logic [3:0]      Operation,
   output logic            MdSel,
   output logic            Stall,
   output logic            MdDone,
   output logic [XLEN-1:0] MdResult
);

   localparam int STEPS = XLEN / UNROLL;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d;      // multiplicand or divisor magnitude
   logic [XLEN-1:0]   hi_q, hi_d;    // product high half / partial remainder
   logic [XLEN-1:0]   lo_q, lo_d;    // multiplier -> product low / dividend -> quotient
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;  // product / quotient must be negated
   logic              negr_q, negr_d; // remainder must be negated
   logic [XLEN-1:0]   res_q, res_d;

   function automatic logic [XLEN-1:0] cneg(input logic en, input logic [XLEN-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cneg2(input logic en, input logic [2*XLEN-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   // Request decode and operand preparation
   logic            is_m, accept, is_div, a_signed, b_signed, a_neg, b_neg;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] a_mag, b_mag, special_res;

   assign is_m     = (ALUOp == 2'b10) && !IsImm && (Funct7 == 7'b0000001);
   assign accept   = (state_q == S_IDLE) && MdValid && is_m && !Flush;
   assign is_div   = Funct3[2];
   // Unsigned rs1: mulhu, divu, remu.  Unsigned rs2: additionally mulhsu.
   assign a_signed = !(Funct3 == 3'b011 || Funct3 == 3'b101 || Funct3 == 3'b111);
   assign b_signed = a_signed && (Funct3 != 3'b010);
   assign a_neg    = a_signed && OpA[XLEN-1];
   assign b_neg    = b_signed && OpB[XLEN-1];
   assign a_mag    = cneg(a_neg, OpA);
   assign b_mag    = cneg(b_neg, OpB);

   assign div_zero = is_div && (OpB == '0);
   assign div_ovf  = is_div && !Funct3[0] && (OpA == {1'b1, {(XLEN-1){1'b0}}}) && (OpB == '1);
   assign special  = div_zero || div_ovf;

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = Funct3[1] ? OpA : '1;
      else if (div_ovf)
         special_res = Funct3[1] ? '0 : OpA;
   end

   // Iteration: UNROLL shift-add or restoring-divide steps per cycle
   logic [XLEN-1:0] hi_v, lo_v;
   logic [XLEN:0]   sum_v;

   always_comb begin
      hi_v  = hi_q;
      lo_v  = lo_q;
      sum_v = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (!f3_q[2]) begin
            sum_v = {1'b0, hi_v} + (lo_v[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
            lo_v  = {sum_v[0], lo_v[XLEN-1:1]};
            hi_v  = sum_v[XLEN:1];
         end else begin
            sum_v = {hi_v, lo_v[XLEN-1]};
            lo_v  = {lo_v[XLEN-2:0], 1'b0};
            if (sum_v >= {1'b0, a_q}) begin
               sum_v    = sum_v - {1'b0, a_q};
               lo_v[0]  = 1'b1;
            end
            hi_v  = sum_v[XLEN-1:0];
         end
      end
   end

   // Sign correction and result selection
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   assign prod_s = cneg2(neg_q, {hi_q, lo_q});
   assign quo_s  = cneg(neg_q, lo_q);
   assign rem_s  = cneg(negr_q, hi_q);

   always_comb begin
      if (f3_q[2])
         fix_res = f3_q[1] ? rem_s : quo_s;
      else if (f3_q[1:0] == 2'b00)
         fix_res = prod_s[XLEN-1:0];
      else
         fix_res = prod_s[2*XLEN-1:XLEN];
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (Flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      Stall  = MdValid && is_m && (state_q != S_DONE) && !Flush;
      MdDone = (state_q == S_DONE) && !Flush;
      MdSel  = is_m;
   end

   assign MdResult = res_q;

   // Datapath next state
   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      f3_d   = f3_q;
      neg_d  = neg_q;
      negr_d = negr_q;
      res_d  = res_q;
      if (accept) begin
         f3_d   = Funct3;
         a_d    = is_div ? b_mag : a_mag;
         lo_d   = is_div ? a_mag : b_mag;
         hi_d   = '0;
         neg_d  = a_neg ^ b_neg;
         negr_d = a_neg;
         cnt_d  = CNT_W'(STEPS - 1);
         if (special)
            res_d = special_res;
      end else if (!Flush && state_q == S_CALC) begin
         hi_d  = hi_v;
         lo_d  = lo_v;
         cnt_d = cnt_q - CNT_W'(1);
      end else if (!Flush && state_q == S_FIX) begin
         res_d = fix_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         negr_q <= 1'b0;
         res_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         f3_q   <= f3_d;
         neg_q  <= neg_d;
         negr_q <= negr_d;
         res_q  <= res_d;
      end
   end

   // ALU operation decode
   always_comb begin
      Operation = 4'b0010;
      case (ALUOp)
         2'b00: Operation = 4'b0010;
         2'b11: Operation = 4'b1010;
         2'b01: begin
            case (Funct3)
               3'b000:  Operation = 4'b1000;
               3'b001:  Operation = 4'b1001;
               3'b100:  Operation = 4'b1100;
               3'b101:  Operation = 4'b1101;
               3'b110:  Operation = 4'b1110;
               3'b111:  Operation = 4'b1111;
               default: Operation = 4'b0010;
            endcase
         end
         default: begin
            if (is_m) begin
               Operation = 4'b0010;
            end else begin
               case (Funct3)
                  // An immediate with bit 30 set is still an add.
                  3'b000:  Operation = (!IsImm && Funct7 == 7'b0100000) ? 4'b0110 : 4'b0010;
                  3'b001:  Operation = 4'b0100;
                  3'b010:  Operation = 4'b1100;
                  3'b011:  Operation = 4'b1110;
                  3'b100:  Operation = 4'b0011;
                  3'b101:  Operation = (Funct7 == 7'b0100000) ? 4'b0111 : 4'b0101;
                  3'b110:  Operation = 4'b0001;
                  default: Operation = 4'b0000;
               endcase
            end
         end
      endcase
   end

endmodule

// File: tb/tb_alu_controller_mdu.sv
module tb_alu_controller_mdu;

   logic        clk;
   logic        rst_n;
   logic [1:0]  ALUOp;
   logic [6:0]  Funct7;
   logic [2:0]  Funct3;
   logic        IsImm;
   logic        MdValid;
   logic        Flush;
   logic [31:0] OpA, OpB;

   logic [3:0]  op1, op4;
   logic        sel1, sel4, stall1, stall4, done1, done4;
   logic [31:0] res1, res4;

   alu_controller_mdu #(.XLEN(32), .UNROLL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
      .IsImm(IsImm), .MdValid(MdValid), .Flush(Flush), .OpA(OpA), .OpB(OpB),
      .Operation(op1), .MdSel(sel1), .Stall(stall1), .MdDone(done1), .MdResult(res1));

   alu_controller_mdu #(.XLEN(32), .UNROLL(4)) u4 (
      .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
      .IsImm(IsImm), .MdValid(MdValid), .Flush(Flush), .OpA(OpA), .OpB(OpB),
      .Operation(op4), .MdSel(sel4), .Stall(stall4), .MdDone(done4), .MdResult(res4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          stamp;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [1:0] aop;
      logic [6:0] f7;
      logic [2:0] f3;
      logic       imm;
      logic [3:0] op;
      logic       sel;
   } dec_t;
   dec_t tbl[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every completion pulse consumes one expected entry.
   always @(negedge clk) begin
      if (rst_n && done1) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got MdDone=1 result=%h expected no completion", res1);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("md_result", res1, e.val);
            chk("md_latency", 32'(cyc - e.stamp), 32'(e.lat));
         end
      end
   end

   task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      ALUOp   = 2'b10;
      Funct7  = 7'b0000001;
      Funct3  = f3;
      IsImm   = 1'b0;
      OpA     = a;
      OpB     = b;
      MdValid = 1'b1;
   endtask

   task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit chk_u4);
      int stalls, u4lat;
      bit got;
      logic [31:0] u4res;
      @(posedge clk); #1;
      drive_m(f3, a, b);
      sbq.push_back('{exp, lat, cyc});
      stalls = 0;
      got    = 1'b0;
      u4lat  = -1;
      u4res  = '0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (chk_u4 && done4 && u4lat < 0) begin
            u4lat = k;
            u4res = res4;
         end
         if (done1) begin
            got = 1'b1;
            break;
         end
         if (stall1) stalls++;
      end
      chk("done_seen", 32'(got), 32'd1);
      if (got) chk("stall_in_done", 32'(stall1), 32'd0);
      chk("stall_cycles", 32'(stalls), 32'(lat));
      if (chk_u4) begin
         chk("u4_latency", 32'(u4lat), 32'd10);
         chk("u4_result", u4res, exp);
      end
      @(posedge clk); #1;
      MdValid = 1'b0;
   endtask

   initial begin
      int ndone;
      rst_n   = 1'b0;
      ALUOp   = 2'b00;
      Funct7  = '0;
      Funct3  = '0;
      IsImm   = 1'b0;
      MdValid = 1'b0;
      Flush   = 1'b0;
      OpA     = '0;
      OpB     = '0;
      #1;
      chk("reset_result", res1, 32'h0);
      chk("reset_done", 32'(done1), 32'd0);
      chk("reset_stall", 32'(stall1), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Decode table: {ALUOp, Funct7, Funct3, IsImm, Operation, MdSel}
      tbl.push_back('{2'b00, 7'b0000000, 3'b010, 1'b0, 4'b0010, 1'b0});
      tbl.push_back('{2'b11, 7'b0000000, 3'b000, 1'b0, 4'b1010, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b000, 1'b0, 4'b1000, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b001, 1'b0, 4'b1001, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b100, 1'b0, 4'b1100, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b101, 1'b0, 4'b1101, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b110, 1'b0, 4'b1110, 1'b0});
      tbl.push_back('{2'b01, 7'b0000000, 3'b111, 1'b0, 4'b1111, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b000, 1'b0, 4'b0010, 1'b0});
      tbl.push_back('{2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0110, 1'b0});
      tbl.push_back('{2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0010, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b001, 1'b0, 4'b0100, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b010, 1'b0, 4'b1100, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b011, 1'b1, 4'b1110, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b100, 1'b0, 4'b0011, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b101, 1'b0, 4'b0101, 1'b0});
      tbl.push_back('{2'b10, 7'b0100000, 3'b101, 1'b0, 4'b0111, 1'b0});
      tbl.push_back('{2'b10, 7'b0100000, 3'b101, 1'b1, 4'b0111, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b110, 1'b0, 4'b0001, 1'b0});
      tbl.push_back('{2'b10, 7'b0000000, 3'b111, 1'b0, 4'b0000, 1'b0});
      tbl.push_back('{2'b10, 7'b0000001, 3'b100, 1'b0, 4'b0010, 1'b1});
      tbl.push_back('{2'b10, 7'b0000001, 3'b111, 1'b0, 4'b0010, 1'b1});
      tbl.push_back('{2'b10, 7'b0000001, 3'b000, 1'b1, 4'b0010, 1'b0});
      foreach (tbl[i]) begin
         ALUOp  = tbl[i].aop;
         Funct7 = tbl[i].f7;
         Funct3 = tbl[i].f3;
         IsImm  = tbl[i].imm;
         #1;
         chk($sformatf("operation[%0d]", i), 32'(op1), 32'(tbl[i].op));
         chk($sformatf("mdsel[%0d]", i), 32'(sel1), 32'(tbl[i].sel));
      end

      // Multiplies (UNROLL=4 instance checked on the first one)
      run_m(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1);
      run_m(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
      run_m(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
      run_m(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
      // Divides
      run_m(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
      run_m(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
      run_m(3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0);
      // Special cases
      run_m(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
      run_m(3'b110, 32'd5,        32'd0,        32'd5,        1,  1'b0);
      run_m(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
      run_m(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
      run_m(3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);

      // Flush at CALC cycle 10: no completion, result held
      @(posedge clk); #1;
      drive_m(3'b000, 32'd7, 32'hFFFFFFFD);
      repeat (10) @(posedge clk);
      #1;
      Flush = 1'b1;
      #1;
      chk("stall_under_flush", 32'(stall1), 32'd0);
      @(posedge clk); #1;
      Flush   = 1'b0;
      MdValid = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done1) ndone++;
      end
      chk("done_after_flush", 32'(ndone), 32'd0);
      chk("result_held_flush", res1, 32'd14);

      // Async reset at CALC cycle 5
      @(posedge clk); #1;
      drive_m(3'b000, 32'd7, 32'hFFFFFFFD);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midop_reset_result", res1, 32'h0);
      chk("midop_reset_done", 32'(done1), 32'd0);
      MdValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_reset_result", res1, 32'h0);

      // Recovery after reset: normal latency from IDLE
      run_m(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
